// File: rtl/poly_feeder_pkg.sv
// Shared types and helpers for the quadratic-datapath operand feeder.
package poly_feeder_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        SETUP,
        PRESS,
        RELEASE,
        WAIT_RES,
        HOLD
    } feeder_state_t;

    typedef enum logic [1:0] {
        IDX_A = 2'd0,
        IDX_B = 2'd1,
        IDX_C = 2'd2,
        IDX_X = 2'd3
    } operand_idx_t;

    // Wide enough to hold the largest (N-1) load value of any timed state.
    function automatic int timer_width(input int setup_cyc, input int go_high_cyc,
                                       input int go_low_cyc, input int result_wait);
        int longest;
        longest = setup_cyc;
        if (go_high_cyc > longest) longest = go_high_cyc;
        if (go_low_cyc > longest) longest = go_low_cyc;
        if (result_wait > longest) longest = result_wait;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/feeder_timer.sv
// Down-counter that measures state dwell time; done is high while the count reads zero.
module feeder_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/poly_operand_feeder.sv
// Collects A, B, C, X, replays each to the quadratic datapath as a timed go press,
// then captures the datapath result and offers it on a valid/ready output.
module poly_operand_feeder
    import poly_feeder_pkg::*;
#(
    parameter int W           = 8,
    parameter int SETUP_CYC   = 1,
    parameter int GO_HIGH_CYC = 2,
    parameter int GO_LOW_CYC  = 2,
    parameter int RESULT_WAIT = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] dp_data,
    output logic         dp_go,
    input  logic [W-1:0] dp_result,
    output logic [W-1:0] out_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int TW = timer_width(SETUP_CYC, GO_HIGH_CYC, GO_LOW_CYC, RESULT_WAIT);

    feeder_state_t state;
    operand_idx_t  idx;
    logic [W-1:0]  operand_buf [4];

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;

    feeder_timer #(
        .TW(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(timer_val),
        .done    (timer_done)
    );

    // Load the timer on the same edge that enters the next timed state.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            COLLECT: begin
                if (in_valid && in_ready && idx == IDX_X) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(GO_HIGH_CYC - 1);
                end
            end
            PRESS: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = TW'(GO_LOW_CYC - 1);
                end
            end
            RELEASE: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    timer_val  = (idx == IDX_X) ? TW'(RESULT_WAIT - 1) : TW'(SETUP_CYC - 1);
                end
            end
            default: begin
                timer_load = 1'b0;
                timer_val  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            idx         <= IDX_A;
            operand_buf <= '{default: '0};
            in_ready    <= 1'b1;
            dp_go       <= 1'b0;
            dp_data     <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid && in_ready) begin
                        operand_buf[idx] <= in_data;
                        if (idx == IDX_X) begin
                            idx      <= IDX_A;
                            state    <= SETUP;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            dp_data  <= operand_buf[IDX_A];
                        end else begin
                            idx <= operand_idx_t'(idx + 2'd1);
                        end
                    end
                end
                SETUP: begin
                    if (timer_done) begin
                        state <= PRESS;
                        dp_go <= 1'b1;
                    end
                end
                PRESS: begin
                    if (timer_done) begin
                        state <= RELEASE;
                        dp_go <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (timer_done) begin
                        if (idx == IDX_X) begin
                            state <= WAIT_RES;
                        end else begin
                            idx     <= operand_idx_t'(idx + 2'd1);
                            dp_data <= operand_buf[operand_idx_t'(idx + 2'd1)];
                            state   <= SETUP;
                        end
                    end
                end
                WAIT_RES: begin
                    if (timer_done) begin
                        out_result <= dp_result;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= IDX_A;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_operand_feeder.sv
// Self-checking bench: feeder paired with a behavioural quadratic datapath, checked
// every cycle against a timeline model plus hand-computed result literals.
module tb_poly_operand_feeder;

    localparam int W           = 8;
    localparam int SETUP_CYC   = 1;
    localparam int GO_HIGH_CYC = 2;
    localparam int GO_LOW_CYC  = 2;
    localparam int RESULT_WAIT = 6;
    localparam int PER         = SETUP_CYC + GO_HIGH_CYC + GO_LOW_CYC;
    localparam int RUN_LEN     = 4 * PER + RESULT_WAIT;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dp_data;
    logic         dp_go;
    logic [W-1:0] dp_result;
    logic [W-1:0] out_result;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    always #5 clk = ~clk;

    poly_operand_feeder #(
        .W          (W),
        .SETUP_CYC  (SETUP_CYC),
        .GO_HIGH_CYC(GO_HIGH_CYC),
        .GO_LOW_CYC (GO_LOW_CYC),
        .RESULT_WAIT(RESULT_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dp_data   (dp_data),
        .dp_go     (dp_go),
        .dp_result (dp_result),
        .out_result(out_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] refPoly(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] x);
        int r;
        r = int'(c) * int'(x) * int'(x) + int'(b) * int'(x) + int'(a);
        return 8'(r % 256);
    endfunction

    function automatic logic [7:0] horner(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] x);
        logic [7:0] h;
        h = c;
        h = h * x + b;
        h = h * x + a;
        return h;
    endfunction

    // Quadratic datapath stand-in: latches data_in on each go rising edge in
    // A, B, C, X order and produces the result a few cycles after X.
    logic [7:0] dpOps [4];
    int         dpCnt;
    int         dpWait;
    logic       dpPrevGo;

    always @(posedge clk) begin
        if (reset) begin
            dpCnt     <= 0;
            dpWait    <= 0;
            dpPrevGo  <= 1'b0;
            dp_result <= '0;
        end else begin
            dpPrevGo <= dp_go;
            if (dp_go && !dpPrevGo) begin
                dpOps[dpCnt] <= dp_data;
                dpCnt        <= (dpCnt == 3) ? 0 : dpCnt + 1;
                if (dpCnt == 3) dpWait <= 3;
            end else if (dpWait != 0) begin
                dpWait <= dpWait - 1;
                if (dpWait == 1) dp_result <= horner(dpOps[0], dpOps[1], dpOps[2], dpOps[3]);
            end
        end
    end

    // Timeline model: mode 0 collecting, 1 replaying (mT cycles since the X
    // handshake), 2 holding the result.
    int         mMode  = 0;
    int         mCnt   = 0;
    int         mT     = 0;
    bit         mValid = 1'b0;
    logic [7:0] mOps [4];
    logic [7:0] mData = '0;
    logic [7:0] mRes  = '0;

    int         cyc        = 0;
    int         hsCycle    = 0;
    int         hsCount    = 0;
    int         lat        = -1;
    int         pulseCount = 0;
    int         pulseLen   = 0;
    int         badPulse   = 0;
    logic       lastGo     = 1'b0;
    logic       lastValid  = 1'b0;
    logic [7:0] lastData   = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mValid) begin
                int  ph;
                bit  expGo;
                if (mMode == 1 && mT < 4 * PER) mData = mOps[mT / PER];
                ph    = mT % PER;
                expGo = (mMode == 1) && (mT < 4 * PER) && (ph >= SETUP_CYC) && (ph < SETUP_CYC + GO_HIGH_CYC);
                checkOutput("cyc_in_ready", 32'(in_ready), 32'(mMode == 0));
                checkOutput("cyc_busy", 32'(busy), 32'(mMode != 0));
                checkOutput("cyc_dp_go", 32'(dp_go), 32'(expGo));
                checkOutput("cyc_dp_data", 32'(dp_data), 32'(mData));
                checkOutput("cyc_out_valid", 32'(out_valid), 32'(mMode == 2));
                checkOutput("cyc_out_result", 32'(out_result), 32'(mRes));

                if (dp_go && lastGo) checkOutput("dp_data_stable_under_go", 32'(dp_data), 32'(lastData));
                if (dp_go && !lastGo) begin
                    pulseCount++;
                    pulseLen = 1;
                end else if (dp_go) begin
                    pulseLen++;
                end
                if (!dp_go && lastGo && pulseLen != GO_HIGH_CYC) badPulse++;
                if (in_valid && in_ready && !reset) hsCount++;
                if (mMode == 0 && mCnt == 3 && in_valid && !reset) hsCycle = cyc;
                if (out_valid && !lastValid) lat = cyc - hsCycle;
                lastGo    = dp_go;
                lastData  = dp_data;
                lastValid = out_valid;
            end

            if (reset) begin
                mValid = 1'b1;
                mMode  = 0;
                mCnt   = 0;
                mT     = 0;
                mData  = '0;
                mRes   = '0;
            end else if (mValid) begin
                case (mMode)
                    0: begin
                        if (in_valid) begin
                            mOps[mCnt] = in_data;
                            if (mCnt == 3) begin
                                mCnt  = 0;
                                mMode = 1;
                                mT    = 0;
                            end else begin
                                mCnt++;
                            end
                        end
                    end
                    1: begin
                        if (mT == RUN_LEN - 1) begin
                            mRes  = refPoly(mOps[0], mOps[1], mOps[2], mOps[3]);
                            mMode = 2;
                        end else begin
                            mT++;
                        end
                    end
                    default: begin
                        if (out_ready) mMode = 0;
                    end
                endcase
            end
        end
    end

    task automatic sendWord(input logic [7:0] w, input int gap);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic [7:0] x, input int maxGap);
        sendWord(a, $urandom_range(0, maxGap));
        sendWord(b, $urandom_range(0, maxGap));
        sendWord(c, $urandom_range(0, maxGap));
        sendWord(x, $urandom_range(0, maxGap));
    endtask

    task automatic waitResult(input string name, input logic [7:0] expected, input int holdCycles);
        int         n;
        logic [7:0] held;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < RUN_LEN + 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checkOutput("result_timeout", 32'(out_valid), 32'd1);
            return;
        end
        checkOutput(name, 32'(out_result), 32'(expected));
        held = out_result;
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_out_result", 32'(out_result), 32'(held));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("accept_in_ready", 32'(in_ready), 32'd1);
        checkOutput("accept_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        logic [7:0] a, b, c, x;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_dp_go", 32'(dp_go), 32'd0);
        checkOutput("reset_dp_data", 32'(dp_data), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_result", 32'(out_result), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        $display("[TB] basic stream 1,2,3,4");
        applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 0);
        waitResult("t1_result", 8'h39, 0);
        checkOutput("t1_latency", 32'(lat), 32'd27);

        $display("[TB] stream 5,10,20,3 with go pulse count");
        pulseCount = 0;
        badPulse   = 0;
        applyStimulus(8'd5, 8'd10, 8'd20, 8'd3, 1);
        waitResult("t2_result", 8'hD7, 0);
        checkOutput("t2_pulse_count", 32'(pulseCount), 32'd4);
        checkOutput("t2_bad_pulse_width", 32'(badPulse), 32'd0);

        $display("[TB] wrap stream 7,0,16,4 with 10-cycle hold");
        applyStimulus(8'd7, 8'd0, 8'd16, 8'd4, 2);
        waitResult("t3_wrap_result", 8'h07, 10);

        $display("[TB] reset during press of C");
        pulseCount = 0;
        applyStimulus(8'd9, 8'd8, 8'd7, 8'd6, 0);
        n = 0;
        while (pulseCount < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("t5_reached_press_c", 32'(pulseCount), 32'd3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t5_dp_go_after_reset", 32'(dp_go), 32'd0);
        checkOutput("t5_in_ready_after_reset", 32'(in_ready), 32'd1);
        checkOutput("t5_busy_after_reset", 32'(busy), 32'd0);
        applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 1);
        waitResult("t5_result_after_reset", 8'h39, 0);

        $display("[TB] gapped stream with in_valid driven while busy");
        hsCount = 0;
        applyStimulus(8'd9, 8'd250, 8'd33, 8'd17, 3);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        waitResult("t6_result", refPoly(8'd9, 8'd250, 8'd33, 8'd17), 3);
        checkOutput("t6_words_consumed", 32'(hsCount), 32'd4);

        $display("[TB] randomized streams");
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            x = 8'($urandom);
            applyStimulus(a, b, c, x, 3);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end
            waitResult("rand_result", refPoly(a, b, c, x), $urandom_range(0, 5));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
